// File: rtl/lsram_arb_pkg.sv
// Shared definitions for the LSRAM port arbiter: FSM state encoding and
// requester indices.
package lsram_arb_pkg;

  typedef enum logic [1:0] {
    ARB  = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } arb_state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Ownership state that belongs to a given requester index.
  function automatic arb_state_e own_state(input logic idx);
    return (idx == REQ1) ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/lsram_rr_pick.sv
// Two-way round-robin picker: with both requesting, the requester that did
// not win last time is chosen. Output is one-hot (or zero when idle).
module lsram_rr_pick
  import lsram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  // Pick one requester; ties go to the one that was not served last.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last == REQ1) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/lsram_port_arbiter.sv
// Shares one LSRAM access port between the AHB SRAM interface (requester 0)
// and a secondary engine (requester 1). Round-robin with optional burst lock
// and a hold limit so a locked burst cannot starve the other side.
module lsram_port_arbiter
  import lsram_arb_pkg::*;
#(
  parameter int MEM_AWIDTH = 19,
  parameter int MAX_HOLD   = 16,
  parameter int HOLD_W     = 8
) (
  input  logic                  HCLK,
  input  logic                  HRESETN,
  input  logic                  m0_req,
  input  logic                  m0_write,
  input  logic                  m0_lock,
  input  logic [MEM_AWIDTH-1:0] m0_addr,
  input  logic [31:0]           m0_wdata,
  input  logic [3:0]            m0_byteen,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic                  m0_busy,
  input  logic                  m1_req,
  input  logic                  m1_write,
  input  logic                  m1_lock,
  input  logic [MEM_AWIDTH-1:0] m1_addr,
  input  logic [31:0]           m1_wdata,
  input  logic [3:0]            m1_byteen,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic                  m1_busy,
  output logic [31:0]           rdata,
  output logic                  mem_write,
  output logic                  mem_read,
  output logic [MEM_AWIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_byteen,
  input  logic [31:0]           mem_rdata
);

  arb_state_e        state_r, state_nxt_s;
  logic              rr_last_r, rr_last_nxt_s;
  logic [HOLD_W-1:0] hold_cnt_r, hold_cnt_nxt_s, hold_try_s;
  logic [1:0]        req_s, pick_s, gnt_s;
  logic              xfer_s, sel_s, sel_write_s, sel_lock_s, other_req_s;
  logic              rvalid0_r, rvalid1_r;

  assign req_s = {m1_req, m0_req};

  lsram_rr_pick u_pick (
    .req   (req_s),
    .last  (rr_last_r),
    .grant (pick_s)
  );

  // Grant: round-robin when unowned, owner-only during a burst, none in reset.
  always_comb begin
    gnt_s = 2'b00;
    if (!HRESETN) begin
      gnt_s = 2'b00;
    end else begin
      case (state_r)
        ARB:     gnt_s = pick_s;
        OWN0:    gnt_s = {1'b0, m0_req};
        OWN1:    gnt_s = {m1_req, 1'b0};
        default: gnt_s = 2'b00;
      endcase
    end
  end

  assign xfer_s      = |gnt_s;
  assign sel_s       = gnt_s[1];
  assign sel_write_s = sel_s ? m1_write : m0_write;
  assign sel_lock_s  = sel_s ? m1_lock : m0_lock;
  assign other_req_s = sel_s ? m0_req : m1_req;

  // Next state: hold_try_s is the burst length including this transfer,
  // counted only while the other side waits; reaching MAX_HOLD forces release.
  always_comb begin
    state_nxt_s    = state_r;
    rr_last_nxt_s  = rr_last_r;
    hold_cnt_nxt_s = hold_cnt_r;
    hold_try_s     = hold_cnt_r;
    if (xfer_s) begin
      rr_last_nxt_s = sel_s;
      if (state_r == ARB) begin
        hold_try_s = HOLD_W'(1);
      end else if (other_req_s) begin
        hold_try_s = hold_cnt_r + HOLD_W'(1);
      end else begin
        hold_try_s = hold_cnt_r;
      end
      if (!sel_lock_s) begin
        state_nxt_s    = ARB;
        hold_cnt_nxt_s = {HOLD_W{1'b0}};
      end else if (other_req_s && (hold_try_s >= HOLD_W'(MAX_HOLD))) begin
        state_nxt_s    = ARB;
        hold_cnt_nxt_s = {HOLD_W{1'b0}};
      end else begin
        state_nxt_s    = own_state(sel_s);
        hold_cnt_nxt_s = hold_try_s;
      end
    end else begin
      state_nxt_s    = state_r;
      rr_last_nxt_s  = rr_last_r;
      hold_cnt_nxt_s = hold_cnt_r;
    end
  end

  // State, round-robin pointer, hold counter and read-return flags.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state_r    <= ARB;
      rr_last_r  <= REQ1;
      hold_cnt_r <= {HOLD_W{1'b0}};
      rvalid0_r  <= 1'b0;
      rvalid1_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      rr_last_r  <= rr_last_nxt_s;
      hold_cnt_r <= hold_cnt_nxt_s;
      rvalid0_r  <= gnt_s[0] & ~m0_write;
      rvalid1_r  <= gnt_s[1] & ~m1_write;
    end
  end

  assign m0_gnt     = gnt_s[0];
  assign m1_gnt     = gnt_s[1];
  assign m0_busy    = gnt_s[1] | (state_r == OWN1);
  assign m1_busy    = gnt_s[0] | (state_r == OWN0);
  assign m0_rvalid  = rvalid0_r;
  assign m1_rvalid  = rvalid1_r;
  assign rdata      = mem_rdata;

  assign mem_write  = xfer_s & sel_write_s;
  assign mem_read   = xfer_s & ~sel_write_s;
  assign mem_addr   = sel_s ? m1_addr : m0_addr;
  assign mem_wdata  = sel_s ? m1_wdata : m0_wdata;
  assign mem_byteen = (xfer_s & sel_write_s) ? (sel_s ? m1_byteen : m0_byteen) : 4'b0000;

endmodule

// File: doc/lsram_port_arbiter.md
Name: lsram_port_arbiter

Overview:
- Shares the single LSRAM access port (write strobe, read strobe, word address, write data, byte enables, one-cycle read latency) between two requesters.
- Requester 0 is the AHB-Lite SRAM interface. Requester 1 is a secondary engine (DMA/initialiser/scrubber).
- Round-robin arbitration, optional burst lock with an anti-starvation hold limit.
- Returns read data to the requester that issued the read, and produces a per-requester busy/stall indication.

Parameters:
- MEM_AWIDTH, 19, width of the SRAM word address bus
- MAX_HOLD, 16, maximum consecutive locked transfers one requester may take while the other is waiting (1..255)
- HOLD_W, 8, width of the hold counter; must satisfy 2**HOLD_W > MAX_HOLD

Ports:
- HCLK  in  1  clock; all logic on rising edge
- HRESETN  in  1  asynchronous, active-low reset
- m0_req  in  1  requester 0 access request, valid this cycle
- m0_write  in  1  1 = write, 0 = read
- m0_lock  in  1  keep ownership after this transfer (burst)
- m0_addr  in  MEM_AWIDTH  word address
- m0_wdata  in  32  write data
- m0_byteen  in  4  byte enables for writes
- m0_gnt  out  1  transfer accepted this cycle
- m0_rvalid  out  1  read data valid for requester 0
- m0_busy  out  1  port held by requester 1 this cycle
- m1_* (req, write, lock, addr, wdata, byteen, gnt, rvalid, busy)  same as m0_*, for requester 1
- rdata  out  32  shared read-data return, qualified by mN_rvalid
- mem_write  out  1  SRAM write strobe
- mem_read  out  1  SRAM read strobe
- mem_addr  out  MEM_AWIDTH  SRAM word address
- mem_wdata  out  32  SRAM write data
- mem_byteen  out  4  SRAM byte enables (0000 on reads)
- mem_rdata  in  32  SRAM read data, valid the cycle after mem_read

Behaviour:
- Reset: HCLK and HRESETN as stated; reset is asynchronous, active-low.
  - State = ARB, rr_last = 1 (requester 0 wins first tie), hold_cnt = 0.
  - rvalid registers = 0, so m0_rvalid = m1_rvalid = 0.
  - Combinational outputs in ARB with no requests: gnt = 0, busy = 0, mem_write = mem_read = 0, mem_byteen = 0000.
  - Reset mid-burst drops ownership; no partial transfer is retained.
- Transfer: mN_req & mN_gnt in the same cycle.
  - Grant and mem_* are combinational from registered state and current inputs; zero added latency.
  - mem_* mux the granted requester's fields. When no grant: mem_write = mem_read = 0, mem_addr/mem_wdata = requester 0 fields, mem_byteen = 0000.
- Read return:
  - rvalid_N registered = (read transfer by N) in the previous cycle.
  - rdata = mem_rdata, passed through unregistered.
  - Reads can be back-to-back, one per cycle, from either requester.
- FSM states:
  - ARB: no owner. Only one requester → that one is granted. Both requesting → grant the one not equal to rr_last. On any transfer, rr_last := granted index.
  - OWN0 / OWN1: owner granted whenever it requests; the other requester's gnt = 0.
- Transitions:
  - ARB → OWNn on a transfer by n with mN_lock = 1; hold_cnt := 1.
  - Transfer with lock = 0 → ARB.
  - Owner req = 0 for one cycle (idle inside burst) keeps ownership; hold_cnt unchanged.
- Anti-starvation:
  - In OWNn, a locked transfer while the other requester is requesting increments hold_cnt.
  - When hold_cnt == MAX_HOLD at a transfer, the next state is forced to ARB with rr_last = n, so the other requester wins the next tie.
  - hold_cnt resets to 0 on entering ARB; it is not incremented while the other is idle.
- mN_busy = other requester's transfer in this cycle, or state = OWN(other).
- Simultaneous events:
  - Both requesting in ARB: only one is granted; the loser holds its request and fields stable until granted.
  - A lock asserted by the losing requester has no effect.

Decomposition:
- Shared package lsram_arb_pkg holds:
  - state encoding constants ARB = 2'b00, OWN0 = 2'b01, OWN1 = 2'b10
  - requester index constants
- Sub-module lsram_rr_pick: combinational 2-way round-robin picker (req[1:0], last → grant one-hot).
- All state, counters and muxing stay in the top.

Test Plan:
- After reset, m0 read addr 0x10 with m1 idle → m0_gnt = 1 same cycle; mem_read = 1, mem_addr = 0x10; next cycle m0_rvalid = 1, rdata = mem_rdata; m1_rvalid = 0.
- Both request continuously, lock = 0 → grants alternate m0, m1, m0, m1…; mem_write/read follow the granted requester.
- m0 locked burst of 8 writes with m1 requesting, MAX_HOLD = 16 → 8 consecutive m0 grants; m1_busy = 1 throughout; m1 granted on the cycle after the last m0 transfer (lock = 0).
- m0 lock held indefinitely, m1 requesting, MAX_HOLD = 4 → exactly 4 m0 grants, then m1 granted, then m0 granted again.
- Interleaved reads m0 @0x20, m1 @0x30 on consecutive cycles → rvalid pulses m0 then m1 on successive cycles with the matching data.
- HRESETN asserted in the middle of an OWN1 burst → all gnt/rvalid deassert immediately; after release, state = ARB and m0 wins the first tie.
